pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
Owns the program counter and sequences instruction fetch against a variable-latency instruction memory using a request/acknowledge handshake. Selects the next PC from sequential (+4), branch, jump and exception sources. Presents fetched instructions to decode with a valid/ready handshake, and discards wrong-path fetches after a redirect. Replaces the free-running PC register plus PCadd4 pairing when the memory is not single-cycle.

Parameters:
RESET_VEC, 32'h0000_0000, value loaded into Address by Reset
EXC_VEC, 32'h0000_0180, redirect target on Exception

Ports:
Clk  in  1  clock, all state updates on rising edge
Reset  in  1  synchronous, active-high reset
Stall  in  1  pipeline hold; blocks new requests and instruction hand-off
BranchTaken  in  1  redirect to BranchTarget
BranchTarget  in  32  branch target address
Jump  in  1  redirect to JumpTarget
JumpTarget  in  32  jump target address
Exception  in  1  redirect to EXC_VEC
ImemReq  out  1  fetch request, one-cycle pulse
ImemAddr  out  32  fetch address, valid when ImemReq=1
ImemAck  in  1  fetch complete; ImemData valid this cycle
ImemData  in  32  fetched word
InstValid  out  1  Inst/InstAddr valid for decode
Inst  out  32  held instruction
InstAddr  out  32  address of held instruction
InstReady  in  1  decode accepts instruction
Address  out  32  current PC (next fetch address)

Behaviour:
- Reset (sync, high): state=BOOT, Address=RESET_VEC, InstValid=0, Inst=0, InstAddr=0, Discard=0. Reset overrides all other inputs. The instruction memory shares Reset and drops outstanding requests.
- States BOOT, REQ, WAIT, HOLD.
  - BOOT: ImemReq=0. Redirects are ignored. Next cycle goes to REQ.
  - REQ: ImemReq = !Stall && !redirect. ImemAddr=Address. When ImemReq=1, go to WAIT; otherwise stay in REQ. ImemAck is ignored in this state.
  - WAIT: ImemReq=0. On ImemAck:
    - if Discard=1: clear Discard, go to REQ.
    - else: Inst<=ImemData, InstAddr<=Address, InstValid<=1, Address<=Address+4, go to HOLD.
  - HOLD: InstValid=1, with Inst and InstAddr held stable. When InstReady && !Stall: InstValid<=0, go to REQ. Stall masks InstReady. ImemAck is ignored in this state.
- Minimum fetch-to-valid latency: request in cycle N, ack in N+1, InstValid=1 in N+2.
- Redirect = Exception | Jump | BranchTaken.
  - Priority: Exception > Jump > BranchTaken.
  - Target bits [1:0] are forced to 0.
  - Redirects take effect regardless of Stall.
- Redirect handling by state (outside BOOT):
  - REQ: Address<=target, stay in REQ, no request issued that cycle.
  - WAIT without ImemAck: Address<=target, Discard<=1.
  - WAIT with ImemAck same cycle: data dropped, Address<=target, go to REQ, Discard stays 0.
  - WAIT with Discard already set: Address is overwritten by the newest target.
  - HOLD: InstValid<=0, instruction dropped, Address<=target, go to REQ.
- Arithmetic: Address+4 wraps modulo 2^32 (32'hFFFF_FFFC to 0).
- ImemAddr and Address are identical whenever ImemReq=1.

Test Plan:
- Reset, then free-run with ack latency 1 and InstReady=1 -> ImemAddr sequence 0,4,8 with a request every 3 cycles; Inst matches ImemData.
- Ack latency 3, InstReady held low 4 cycles -> InstValid stays high, Inst/InstAddr stable, no ImemReq until InstReady.
- Jump to 32'h40 (Jump=1) while in WAIT, ack 2 cycles later -> that ack's data never appears; next ImemAddr=32'h40.
- Exception, Jump and BranchTaken asserted together with BranchTarget=8, JumpTarget=16 -> next ImemAddr=32'h180.
- Start at Address 32'hFFFF_FFFC, single fetch -> InstAddr=32'hFFFF_FFFC, next ImemAddr=0. Separately, BranchTarget=32'h23 -> ImemAddr=32'h20.
- Reset asserted in HOLD with Stall=1 -> next cycle InstValid=0, Address=RESET_VEC; BOOT lasts one cycle, then ImemReq=1.

Source files
------------

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: owns the PC, fetches from a variable-latency
// instruction memory over a req/ack handshake, and hands fetched words to
// decode over a valid/ready handshake. Redirects (exception, jump, branch)
// retarget the PC and squash any wrong-path fetch still in flight.
module pc_sequencer #(
    parameter logic [31:0] RESET_VEC = 32'h0000_0000,
    parameter logic [31:0] EXC_VEC   = 32'h0000_0180
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_stall,
    input  logic        i_branch_taken,
    input  logic [31:0] i_branch_target,
    input  logic        i_jump,
    input  logic [31:0] i_jump_target,
    input  logic        i_exception,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_ack,
    input  logic [31:0] i_imem_data,
    output logic        o_inst_valid,
    output logic [31:0] o_inst,
    output logic [31:0] o_inst_addr,
    input  logic        i_inst_ready,
    output logic [31:0] o_address
);

    typedef enum logic [1:0] {
        StBoot,
        StReq,
        StWait,
        StHold
    } state_e;

    state_e      r_state;
    state_e      w_state_next;
    logic [31:0] r_address;
    logic [31:0] w_address_next;
    logic [31:0] r_inst;
    logic [31:0] w_inst_next;
    logic [31:0] r_inst_addr;
    logic [31:0] w_inst_addr_next;
    logic        r_inst_valid;
    logic        w_inst_valid_next;
    // Set when the outstanding fetch belongs to a path that was redirected away
    logic        r_discard;
    logic        w_discard_next;

    logic        w_redirect;
    logic [31:0] w_target_raw;
    logic [31:0] w_target;
    logic        w_imem_req;

    // Redirect source selection: exception beats jump beats branch; targets word-aligned
    always_comb begin
        w_redirect   = i_exception | i_jump | i_branch_taken;
        w_target_raw = i_branch_target;
        if (i_exception) begin
            w_target_raw = EXC_VEC;
        end else if (i_jump) begin
            w_target_raw = i_jump_target;
        end
        w_target = {w_target_raw[31:2], 2'b00};
    end

    // Next-state, next-PC and fetch request decode
    always_comb begin
        w_state_next      = r_state;
        w_address_next    = r_address;
        w_inst_next       = r_inst;
        w_inst_addr_next  = r_inst_addr;
        w_inst_valid_next = r_inst_valid;
        w_discard_next    = r_discard;
        w_imem_req        = 1'b0;

        unique case (r_state)
            StBoot: begin
                // Redirects are ignored for the single boot cycle
                w_state_next = StReq;
            end
            StReq: begin
                if (w_redirect) begin
                    w_address_next = w_target;
                end else if (!i_stall) begin
                    w_imem_req   = 1'b1;
                    w_state_next = StWait;
                end
            end
            StWait: begin
                if (i_imem_ack) begin
                    w_state_next   = StReq;
                    w_discard_next = 1'b0;
                    if (w_redirect) begin
                        // Data returned on the same cycle as a redirect is wrong-path
                        w_address_next = w_target;
                    end else if (!r_discard) begin
                        w_inst_next       = i_imem_data;
                        w_inst_addr_next  = r_address;
                        w_inst_valid_next = 1'b1;
                        w_address_next    = r_address + 32'd4;
                        w_state_next      = StHold;
                    end
                end else if (w_redirect) begin
                    // Memory still owes us a word; remember to throw it away
                    w_address_next = w_target;
                    w_discard_next = 1'b1;
                end
            end
            StHold: begin
                if (w_redirect) begin
                    w_inst_valid_next = 1'b0;
                    w_address_next    = w_target;
                    w_state_next      = StReq;
                end else if (i_inst_ready && !i_stall) begin
                    w_inst_valid_next = 1'b0;
                    w_state_next      = StReq;
                end
            end
            default: begin
                w_state_next = StBoot;
            end
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= StBoot;
            r_address    <= RESET_VEC;
            r_inst       <= 32'd0;
            r_inst_addr  <= 32'd0;
            r_inst_valid <= 1'b0;
            r_discard    <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_address    <= w_address_next;
            r_inst       <= w_inst_next;
            r_inst_addr  <= w_inst_addr_next;
            r_inst_valid <= w_inst_valid_next;
            r_discard    <= w_discard_next;
        end
    end

    assign o_imem_req   = w_imem_req;
    assign o_imem_addr  = r_address;
    assign o_address    = r_address;
    assign o_inst_valid = r_inst_valid;
    assign o_inst       = r_inst;
    assign o_inst_addr  = r_inst_addr;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: a latency-programmable memory model
// plus a transaction-level reference model of the fetch stream.
module tb_pc_sequencer;

    localparam logic [31:0] RESET_VEC = 32'h0000_0000;
    localparam logic [31:0] EXC_VEC   = 32'h0000_0180;

    logic        clk = 1'b0;
    logic        rst, stall, br, jmp, exc, ack, ready;
    logic [31:0] bt, jt, data;
    logic        req, ivalid;
    logic [31:0] iaddr, inst, inst_addr, addr;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int k_lat  = 1;
    bit spur_en = 1'b0;

    // Memory model
    bit          mem_pend = 1'b0;
    int          mem_wait = 0;
    logic [31:0] mem_data;

    // Reference model: expected PC, one outstanding fetch, one held instruction
    bit          m_boot, m_out, m_stale, m_held;
    logic [31:0] m_pc, m_out_addr, m_held_data, m_held_addr;

    logic [31:0] q_req_addr[$];
    int          q_req_cyc[$];

    always #5 clk = ~clk;

    pc_sequencer #(
        .RESET_VEC(RESET_VEC),
        .EXC_VEC  (EXC_VEC)
    ) dut (
        .i_clk          (clk),
        .i_reset        (rst),
        .i_stall        (stall),
        .i_branch_taken (br),
        .i_branch_target(bt),
        .i_jump         (jmp),
        .i_jump_target  (jt),
        .i_exception    (exc),
        .o_imem_req     (req),
        .o_imem_addr    (iaddr),
        .i_imem_ack     (ack),
        .i_imem_data    (data),
        .o_inst_valid   (ivalid),
        .o_inst         (inst),
        .o_inst_addr    (inst_addr),
        .i_inst_ready   (ready),
        .o_address      (addr)
    );

    // One clock cycle: drive memory ack, check and advance the model at negedge.
    task automatic tick();
        logic        redir;
        logic [31:0] tgt;
        bit          exp_req;
        ack = 1'b0;
        if (mem_pend) begin
            mem_wait--;
            if (mem_wait <= 0) begin
                ack      = 1'b1;
                data     = mem_data;
                mem_pend = 1'b0;
            end
        end else if (spur_en && $urandom_range(0, 19) == 0) begin
            ack  = 1'b1;
            data = $urandom;
        end
        @(negedge clk);
        if (rst) begin
            m_pc = RESET_VEC; m_boot = 1'b1; m_out = 1'b0; m_held = 1'b0; m_stale = 1'b0;
            mem_pend = 1'b0;
        end else begin
            redir = exc | jmp | br;
            tgt   = exc ? EXC_VEC : (jmp ? jt : bt);
            tgt[1:0] = 2'b00;
            exp_req = !m_boot && !m_out && !m_held && !stall && !redir;
            checks++;
            if (addr !== m_pc) begin
                errors++;
                $display("FAIL address cyc %0d: got %h expected %h", cyc, addr, m_pc);
            end
            checks++;
            if (ivalid !== m_held) begin
                errors++;
                $display("FAIL inst_valid cyc %0d: got %b expected %b", cyc, ivalid, m_held);
            end
            if (m_held) begin
                checks++;
                if (inst !== m_held_data || inst_addr !== m_held_addr) begin
                    errors++;
                    $display("FAIL held_inst cyc %0d: got %h@%h expected %h@%h", cyc, inst,
                             inst_addr, m_held_data, m_held_addr);
                end
            end
            checks++;
            if (req !== exp_req) begin
                errors++;
                $display("FAIL imem_req cyc %0d: got %b expected %b", cyc, req, exp_req);
            end
            if (exp_req) begin
                checks++;
                if (iaddr !== m_pc) begin
                    errors++;
                    $display("FAIL imem_addr cyc %0d: got %h expected %h", cyc, iaddr, m_pc);
                end
            end
            if (req === 1'b1) begin
                q_req_addr.push_back(iaddr);
                q_req_cyc.push_back(cyc);
                mem_pend = 1'b1;
                mem_wait = k_lat;
                mem_data = $urandom;
            end
            if (m_boot) begin
                m_boot = 1'b0;
            end else begin
                if (m_out && ack) begin
                    m_out = 1'b0;
                    if (!m_stale && !redir) begin
                        m_held = 1'b1; m_held_data = data; m_held_addr = m_out_addr;
                        m_pc = m_out_addr + 32'd4;
                    end
                end else if (m_held && ready && !stall) begin
                    m_held = 1'b0;
                end
                if (redir) begin
                    m_pc = tgt;
                    m_held = 1'b0;
                    if (m_out) m_stale = 1'b1;
                end
                if (exp_req) begin
                    m_out = 1'b1; m_stale = 1'b0; m_out_addr = m_pc;
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        br = 1'b0; jmp = 1'b0; exc = 1'b0; ack = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++;
        if (ivalid !== 1'b0 || inst !== 32'd0 || inst_addr !== 32'd0) begin
            errors++;
            $display("FAIL reset_inst: got v=%b %h@%h expected 0 0@0", ivalid, inst, inst_addr);
        end
        checks++;
        if (addr !== RESET_VEC) begin
            errors++;
            $display("FAIL reset_address: got %h expected %h", addr, RESET_VEC);
        end
        checks++;
        if (req !== 1'b0) begin
            errors++;
            $display("FAIL boot_no_req: got %b expected 0", req);
        end
        tick();
        checks++;
        if (req !== 1'b1 || iaddr !== RESET_VEC) begin
            errors++;
            $display("FAIL first_req: got %b@%h expected 1@%h", req, iaddr, RESET_VEC);
        end
    endtask

    task automatic test_free_run();
        k_lat = 1; ready = 1'b1; stall = 1'b0;
        q_req_addr.delete(); q_req_cyc.delete();
        repeat (10) tick();
        checks++;
        if (q_req_addr.size() < 3) begin
            errors++;
            $display("FAIL free_run_count: got %0d expected >= 3", q_req_addr.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (q_req_addr[i] !== RESET_VEC + 32'(4 * i)) begin
                    errors++;
                    $display("FAIL free_run_addr%0d: got %h expected %h", i, q_req_addr[i],
                             RESET_VEC + 32'(4 * i));
                end
            end
            for (int i = 1; i < 3; i++) begin
                checks++;
                if (q_req_cyc[i] - q_req_cyc[i-1] != 3) begin
                    errors++;
                    $display("FAIL free_run_spacing%0d: got %0d expected 3", i,
                             q_req_cyc[i] - q_req_cyc[i-1]);
                end
            end
        end
    endtask

    task automatic test_hold_stable();
        int          n;
        logic [31:0] h_inst, h_addr;
        k_lat = 3; ready = 1'b0; stall = 1'b0;
        n = 0;
        while (ivalid !== 1'b1 && n < 30) begin tick(); n++; end
        checks++;
        if (ivalid !== 1'b1) begin
            errors++;
            $display("FAIL hold_reach_valid: got %b expected 1", ivalid);
        end
        h_inst = inst; h_addr = inst_addr;
        q_req_addr.delete(); q_req_cyc.delete();
        repeat (4) begin
            tick();
            checks++;
            if (ivalid !== 1'b1 || inst !== h_inst || inst_addr !== h_addr) begin
                errors++;
                $display("FAIL hold_stable: got %b %h@%h expected 1 %h@%h", ivalid, inst,
                         inst_addr, h_inst, h_addr);
            end
        end
        checks++;
        if (q_req_addr.size() != 0) begin
            errors++;
            $display("FAIL hold_no_req: got %0d expected 0", q_req_addr.size());
        end
        ready = 1'b1;
        tick();
        checks++;
        if (req !== 1'b1 || iaddr !== h_addr + 32'd4) begin
            errors++;
            $display("FAIL hold_release_req: got %b@%h expected 1@%h", req, iaddr, h_addr + 32'd4);
        end
    endtask

    task automatic test_redirect_wait();
        int n;
        k_lat = 3; ready = 1'b1; stall = 1'b0;
        q_req_addr.delete(); q_req_cyc.delete();
        n = 0;
        while (q_req_addr.size() == 0 && n < 30) begin tick(); n++; end
        jmp = 1'b1; jt = 32'h0000_0040;
        tick();
        tick();
        tick();
        checks++;
        if (ivalid !== 1'b0) begin
            errors++;
            $display("FAIL discard_no_valid: got %b expected 0", ivalid);
        end
        q_req_addr.delete(); q_req_cyc.delete();
        tick();
        checks++;
        if (q_req_addr.size() != 1 || q_req_addr[0] !== 32'h40) begin
            errors++;
            $display("FAIL jump_refetch: got %0d reqs first %h expected 1 at 00000040",
                     q_req_addr.size(), (q_req_addr.size() > 0) ? q_req_addr[0] : 32'hx);
        end
        n = 0;
        while (ivalid !== 1'b1 && n < 30) begin tick(); n++; end
        checks++;
        if (ivalid !== 1'b1 || inst_addr !== 32'h40) begin
            errors++;
            $display("FAIL jump_inst_addr: got %b@%h expected 1@00000040", ivalid, inst_addr);
        end
    endtask

    task automatic test_priority();
        int n;
        ready = 1'b1; stall = 1'b0; k_lat = 2;
        n = 0;
        while (req !== 1'b1 && n < 30) begin tick(); n++; end
        exc = 1'b1; jmp = 1'b1; br = 1'b1; bt = 32'd8; jt = 32'd16;
        tick();
        checks++;
        if (addr !== EXC_VEC || req !== 1'b1 || iaddr !== EXC_VEC) begin
            errors++;
            $display("FAIL priority: got addr %h req %b@%h expected %h 1@%h", addr, req, iaddr,
                     EXC_VEC, EXC_VEC);
        end
    endtask

    task automatic test_wrap();
        int n;
        ready = 1'b1; stall = 1'b0; k_lat = 1;
        n = 0;
        while (req !== 1'b1 && n < 30) begin tick(); n++; end
        br = 1'b1; bt = 32'hFFFF_FFFC;
        tick();
        checks++;
        if (req !== 1'b1 || iaddr !== 32'hFFFF_FFFC) begin
            errors++;
            $display("FAIL wrap_start: got %b@%h expected 1@fffffffc", req, iaddr);
        end
        n = 0;
        while (ivalid !== 1'b1 && n < 30) begin tick(); n++; end
        checks++;
        if (ivalid !== 1'b1 || inst_addr !== 32'hFFFF_FFFC) begin
            errors++;
            $display("FAIL wrap_inst_addr: got %b@%h expected 1@fffffffc", ivalid, inst_addr);
        end
        n = 0;
        while (req !== 1'b1 && n < 30) begin tick(); n++; end
        checks++;
        if (req !== 1'b1 || iaddr !== 32'h0) begin
            errors++;
            $display("FAIL wrap_next: got %b@%h expected 1@00000000", req, iaddr);
        end
        br = 1'b1; bt = 32'h0000_0023;
        tick();
        checks++;
        if (req !== 1'b1 || iaddr !== 32'h20) begin
            errors++;
            $display("FAIL align_target: got %b@%h expected 1@00000020", req, iaddr);
        end
    endtask

    task automatic test_reset_in_hold();
        int n;
        stall = 1'b0; ready = 1'b0; k_lat = 2;
        n = 0;
        while (ivalid !== 1'b1 && n < 30) begin tick(); n++; end
        stall = 1'b1; ready = 1'b1;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0; stall = 1'b0;
        checks++;
        if (ivalid !== 1'b0 || addr !== RESET_VEC || req !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_hold: got v=%b addr %h req %b expected 0 %h 0", ivalid,
                     addr, req, RESET_VEC);
        end
        tick();
        checks++;
        if (req !== 1'b1 || iaddr !== RESET_VEC) begin
            errors++;
            $display("FAIL reset_boot_len: got %b@%h expected 1@%h", req, iaddr, RESET_VEC);
        end
    endtask

    task automatic test_random();
        spur_en = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            stall = ($urandom_range(0, 3) == 0);
            ready = ($urandom_range(0, 9) < 7);
            exc   = ($urandom_range(0, 49) == 0);
            jmp   = ($urandom_range(0, 24) == 0);
            br    = ($urandom_range(0, 19) == 0);
            bt    = $urandom;
            jt    = $urandom;
            k_lat = $urandom_range(1, 4);
            rst   = ($urandom_range(0, 299) == 0);
            tick();
        end
        rst = 1'b0; stall = 1'b0; spur_en = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; stall = 1'b0; br = 1'b0; jmp = 1'b0; exc = 1'b0; ack = 1'b0;
        ready = 1'b1; bt = 32'd0; jt = 32'd0; data = 32'd0;
        test_reset();
        test_free_run();
        test_hold_stable();
        test_redirect_wait();
        test_priority();
        test_wrap();
        test_reset_in_hold();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
